// File: rtl/cond_flag_unit_pkg.sv
// Shared encodings for ARM condition evaluation: condition codes, NZCV bit
// positions and flag-write select bits.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_flag_unit_cond_check.sv
// Pure combinational ARM condition evaluation against an NZCV vector.
// Shared with the decode-stage early branch predictor.
import cond_pkg::*;

module cond_check (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// EX-stage NZCV register, condition gating and branch resolution; flags and
// predictor update take effect one cycle later. BRANCH_STATS_EN adds branch counters.
import cond_pkg::*;

module cond_flag_unit #(
  parameter int STAT_W = 32
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              Stall_E,
  input  logic              Flush_E,
  input  logic [3:0]        Cond_E,
  input  logic [3:0]        ALUFlags,
  input  logic [1:0]        FlagW_E,
  input  logic              PCS_E,
  input  logic              Branch_E,
  input  logic              RegW_E,
  input  logic              MemW_E,
  input  logic              NoWrite_E,
  input  logic              PredTaken_E,
  output logic [3:0]        Flags,
  output logic              C_to_ALU,
  output logic              CondEx_E,
  output logic              PCSrc_E,
  output logic              RegWrite_E,
  output logic              MemWrite_E,
  output logic              Mispredict_E,
  output logic              ActualTaken_E,
  output logic              UpdValid,
  output logic              UpdTaken,
  output logic [STAT_W-1:0] BrCount,
  output logic [STAT_W-1:0] MispCount
);

  logic cond_pass;
  logic live;

  // Condition is judged on the registered flags only; ALUFlags is never bypassed.
  cond_check u_cond_check (
    .cond  (Cond_E),
    .flags (Flags),
    .pass  (cond_pass)
  );

  assign live          = !Flush_E & !Stall_E;
  assign CondEx_E      = cond_pass & !Flush_E;
  assign PCSrc_E       = PCS_E & CondEx_E;
  assign RegWrite_E    = RegW_E & CondEx_E & !NoWrite_E;
  assign MemWrite_E    = MemW_E & CondEx_E;
  assign ActualTaken_E = CondEx_E;
  assign Mispredict_E  = live & Branch_E & (CondEx_E != PredTaken_E);
  assign C_to_ALU      = Flags[FLAG_C];

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      Flags    <= 4'b0000;
      UpdValid <= 1'b0;
      UpdTaken <= 1'b0;
    end else begin
      if (live & CondEx_E & FlagW_E[FLAGW_NZ]) begin
        Flags[FLAG_N] <= ALUFlags[FLAG_N];
        Flags[FLAG_Z] <= ALUFlags[FLAG_Z];
      end
      if (live & CondEx_E & FlagW_E[FLAGW_CV]) begin
        Flags[FLAG_C] <= ALUFlags[FLAG_C];
        Flags[FLAG_V] <= ALUFlags[FLAG_V];
      end
      UpdValid <= live & Branch_E;
      UpdTaken <= CondEx_E;
    end
  end

`ifdef BRANCH_STATS_EN
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

  // Saturating counters: they park at all-ones rather than wrapping.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      BrCount   <= '0;
      MispCount <= '0;
    end else begin
      if (live & Branch_E & ~&BrCount)
        BrCount <= BrCount + STAT_ONE;
      if (Mispredict_E & ~&MispCount)
        MispCount <= MispCount + STAT_ONE;
    end
  end
`else
  assign BrCount   = '0;
  assign MispCount = '0;
`endif

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed self-checking bench for cond_flag_unit (optionally with BRANCH_STATS_EN).
import cond_pkg::*;

module tb_cond_flag_unit;

  logic        CLK = 1'b0;
  logic        RESETn, Stall_E, Flush_E;
  logic [3:0]  Cond_E, ALUFlags;
  logic [1:0]  FlagW_E;
  logic        PCS_E, Branch_E, RegW_E, MemW_E, NoWrite_E, PredTaken_E;
  logic [3:0]  Flags;
  logic        C_to_ALU, CondEx_E, PCSrc_E, RegWrite_E, MemWrite_E;
  logic        Mispredict_E, ActualTaken_E, UpdValid, UpdTaken;
  logic [31:0] BrCount, MispCount;
  logic [3:0]  Flags4;
  logic        C4, Cx4, Pc4, Rw4, Mw4, Mp4, At4, Uv4, Ut4;
  logic [3:0]  BrCount4, MispCount4;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  cond_flag_unit #(.STAT_W(32)) dut (
    .CLK(CLK), .RESETn(RESETn), .Stall_E(Stall_E), .Flush_E(Flush_E),
    .Cond_E(Cond_E), .ALUFlags(ALUFlags), .FlagW_E(FlagW_E), .PCS_E(PCS_E),
    .Branch_E(Branch_E), .RegW_E(RegW_E), .MemW_E(MemW_E), .NoWrite_E(NoWrite_E),
    .PredTaken_E(PredTaken_E), .Flags(Flags), .C_to_ALU(C_to_ALU),
    .CondEx_E(CondEx_E), .PCSrc_E(PCSrc_E), .RegWrite_E(RegWrite_E),
    .MemWrite_E(MemWrite_E), .Mispredict_E(Mispredict_E),
    .ActualTaken_E(ActualTaken_E), .UpdValid(UpdValid), .UpdTaken(UpdTaken),
    .BrCount(BrCount), .MispCount(MispCount)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  cond_flag_unit #(.STAT_W(4)) dut4 (
    .CLK(CLK), .RESETn(RESETn), .Stall_E(Stall_E), .Flush_E(Flush_E),
    .Cond_E(Cond_E), .ALUFlags(ALUFlags), .FlagW_E(FlagW_E), .PCS_E(PCS_E),
    .Branch_E(Branch_E), .RegW_E(RegW_E), .MemW_E(MemW_E), .NoWrite_E(NoWrite_E),
    .PredTaken_E(PredTaken_E), .Flags(Flags4), .C_to_ALU(C4),
    .CondEx_E(Cx4), .PCSrc_E(Pc4), .RegWrite_E(Rw4),
    .MemWrite_E(Mw4), .Mispredict_E(Mp4),
    .ActualTaken_E(At4), .UpdValid(Uv4), .UpdTaken(Ut4),
    .BrCount(BrCount4), .MispCount(MispCount4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    Stall_E = 0; Flush_E = 0; Cond_E = COND_AL; ALUFlags = 4'b0000;
    FlagW_E = 2'b00; PCS_E = 0; Branch_E = 0; RegW_E = 0; MemW_E = 0;
    NoWrite_E = 0; PredTaken_E = 0;
  endtask

  initial begin
    idle();
    RESETn = 0; Stall_E = 1;
    tick(); tick();
    chk("rst_flags", 32'(Flags), 32'h0);
    chk("rst_c_to_alu", 32'(C_to_ALU), 32'h0);
    chk("rst_updvalid", 32'(UpdValid), 32'h0);
    chk("rst_updtaken", 32'(UpdTaken), 32'h0);
    chk("rst_brcount", BrCount, 32'h0);
    chk("rst_mispcount", MispCount, 32'h0);
    RESETn = 1; Stall_E = 0;

    // AL, write all flags with 0100
    FlagW_E = 2'b11; ALUFlags = 4'b0100; #1;
    chk("al_condex", 32'(CondEx_E), 32'h1);
    chk("no_bypass_flags", 32'(Flags), 32'h0);
    tick();
    chk("flags_0100", 32'(Flags), 32'h4);
    idle(); Cond_E = COND_EQ; #1;
    chk("eq_after_z", 32'(CondEx_E), 32'h1);
    Cond_E = COND_NE; #1;
    chk("ne_after_z", 32'(CondEx_E), 32'h0);

    // Partial flag write: only N,Z from 1011 over 0110
    idle(); FlagW_E = 2'b11; ALUFlags = 4'b0110;
    tick();
    chk("flags_0110", 32'(Flags), 32'h6);
    chk("c_to_alu_1", 32'(C_to_ALU), 32'h1);
    FlagW_E = 2'b10; ALUFlags = 4'b1011;
    tick();
    chk("flags_nz_only", 32'(Flags), 32'hA);

    // Failing condition and flush must not write flags
    Cond_E = COND_EQ; FlagW_E = 2'b11; ALUFlags = 4'b0100;
    tick();
    chk("flags_cond_fail", 32'(Flags), 32'hA);
    idle(); Flush_E = 1; FlagW_E = 2'b11; ALUFlags = 4'b1111;
    tick();
    chk("flags_flush", 32'(Flags), 32'hA);

    // Flags = 1001 (N=V=1, Z=C=0)
    idle(); FlagW_E = 2'b11; ALUFlags = 4'b1001;
    tick();
    chk("flags_1001", 32'(Flags), 32'h9);
    idle(); Cond_E = COND_GE; #1; chk("ge", 32'(CondEx_E), 32'h1);
    Cond_E = COND_LT; #1; chk("lt", 32'(CondEx_E), 32'h0);
    Cond_E = COND_GT; #1; chk("gt", 32'(CondEx_E), 32'h1);
    Cond_E = COND_LE; #1; chk("le", 32'(CondEx_E), 32'h0);
    Cond_E = COND_HI; #1; chk("hi", 32'(CondEx_E), 32'h0);
    Cond_E = COND_LS; #1; chk("ls", 32'(CondEx_E), 32'h1);
    Cond_E = COND_MI; #1; chk("mi", 32'(CondEx_E), 32'h1);
    Cond_E = COND_VC; #1; chk("vc", 32'(CondEx_E), 32'h0);
    Cond_E = COND_NV; RegW_E = 1; #1;
    chk("nv_condex", 32'(CondEx_E), 32'h0);
    chk("nv_regwrite", 32'(RegWrite_E), 32'h0);
    Cond_E = COND_AL; #1;
    chk("al_regwrite", 32'(RegWrite_E), 32'h1);
    NoWrite_E = 1; #1;
    chk("nowrite_regwrite", 32'(RegWrite_E), 32'h0);
    idle(); MemW_E = 1; PCS_E = 1; #1;
    chk("al_memwrite", 32'(MemWrite_E), 32'h1);
    chk("al_pcsrc", 32'(PCSrc_E), 32'h1);
    Cond_E = COND_EQ; #1;
    chk("eq_memwrite_fail", 32'(MemWrite_E), 32'h0);
    chk("eq_pcsrc_fail", 32'(PCSrc_E), 32'h0);

    // Branch 1: EQ with Z=0, predicted taken -> mispredict, not taken
    idle(); Branch_E = 1; Cond_E = COND_EQ; PredTaken_E = 1; #1;
    chk("br1_misp", 32'(Mispredict_E), 32'h1);
    chk("br1_actual", 32'(ActualTaken_E), 32'h0);
    tick();
    chk("br1_updvalid", 32'(UpdValid), 32'h1);
    chk("br1_updtaken", 32'(UpdTaken), 32'h0);
    idle();
    tick();
    chk("br1_updvalid_drop", 32'(UpdValid), 32'h0);

    // Branch 2: same branch held by stall for 3 cycles
    Branch_E = 1; Cond_E = COND_EQ; PredTaken_E = 1; Stall_E = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_misp", 32'(Mispredict_E), 32'h0);
      tick();
      chk("stall_updvalid", 32'(UpdValid), 32'h0);
      chk("stall_flags", 32'(Flags), 32'h9);
    end
    Stall_E = 0; #1;
    chk("unstall_misp", 32'(Mispredict_E), 32'h1);
    tick();
    chk("unstall_updvalid", 32'(UpdValid), 32'h1);
    chk("unstall_updtaken", 32'(UpdTaken), 32'h0);
    idle();
    tick();
    chk("unstall_updvalid_drop", 32'(UpdValid), 32'h0);

    // Stalled flag-setting AL op leaves flags alone
    Stall_E = 1; FlagW_E = 2'b11; ALUFlags = 4'b0100;
    tick();
    chk("stall_no_flagw", 32'(Flags), 32'h9);

    // Branch 3: NE taken, predicted taken
    idle(); Branch_E = 1; Cond_E = COND_NE; PredTaken_E = 1; #1;
    chk("br3_misp", 32'(Mispredict_E), 32'h0);
    chk("br3_actual", 32'(ActualTaken_E), 32'h1);
    tick();
    chk("br3_updvalid", 32'(UpdValid), 32'h1);
    chk("br3_updtaken", 32'(UpdTaken), 32'h1);

    // Branch 4: EQ not taken, predicted not taken
    Cond_E = COND_EQ; PredTaken_E = 0; #1;
    chk("br4_misp", 32'(Mispredict_E), 32'h0);
    tick();
    chk("br4_updtaken", 32'(UpdTaken), 32'h0);

    // Flush and stall+flush: everything gated, no state change
    idle(); Flush_E = 1; PCS_E = 1; RegW_E = 1; MemW_E = 1; Branch_E = 1;
    FlagW_E = 2'b11; ALUFlags = 4'b0110; #1;
    chk("flush_condex", 32'(CondEx_E), 32'h0);
    chk("flush_pcsrc", 32'(PCSrc_E), 32'h0);
    chk("flush_regwrite", 32'(RegWrite_E), 32'h0);
    chk("flush_memwrite", 32'(MemWrite_E), 32'h0);
    chk("flush_misp", 32'(Mispredict_E), 32'h0);
    tick();
    chk("flush_updvalid", 32'(UpdValid), 32'h0);
    chk("flush_flags", 32'(Flags), 32'h9);
    Stall_E = 1; #1;
    chk("stallflush_regwrite", 32'(RegWrite_E), 32'h0);
    tick();
    chk("stallflush_flags", 32'(Flags), 32'h9);

    // Branch 5: flag-setting AL branch, predicted taken; both effects happen
    idle(); Branch_E = 1; PredTaken_E = 1; FlagW_E = 2'b11; ALUFlags = 4'b0100; #1;
    chk("br5_misp", 32'(Mispredict_E), 32'h0);
    tick();
    chk("br5_flags", 32'(Flags), 32'h4);
    chk("br5_updvalid", 32'(UpdValid), 32'h1);
    chk("br5_updtaken", 32'(UpdTaken), 32'h1);
    idle();
    tick();

`ifdef BRANCH_STATS_EN
    chk("brcount_5", BrCount, 32'd5);
    chk("mispcount_2", MispCount, 32'd2);
    chk("brcount4_5", 32'(BrCount4), 32'd5);
    // 12 more correctly predicted AL branches push the 4-bit counter past 15
    Branch_E = 1; PredTaken_E = 1;
    for (int i = 0; i < 12; i++) tick();
    idle();
    tick();
    chk("brcount_17", BrCount, 32'd17);
    chk("brcount4_sat", 32'(BrCount4), 32'd15);
    chk("mispcount4_2", 32'(MispCount4), 32'd2);
`else
    chk("brcount_off", BrCount, 32'h0);
    chk("mispcount_off", MispCount, 32'h0);
    chk("brcount4_off", 32'(BrCount4), 32'h0);
`endif

    // Reset clears flags even while stalled
    RESETn = 0; Stall_E = 1;
    tick();
    chk("rst2_flags", 32'(Flags), 32'h0);
    chk("rst2_brcount", BrCount, 32'h0);
    RESETn = 1; Stall_E = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
